// File: rtl/memfifo_pkg.sv
// memfifo_pkg: shared state encoding and K-word constants for the MEMFIFO serializer.
`default_nettype none

package memfifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOF   = 3'd1,
        ST_LEN   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_CRC   = 3'd4,
        ST_EOF   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic [15:0] K_IDLE   = 16'h3CBC;
    localparam logic [15:0] K_SOF    = 16'h1C1C;
    localparam logic [15:0] K_EOF    = 16'h9C9C;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [1:0] KF_IDLE = 2'b01;
    localparam logic [1:0] KF_CTRL = 2'b11;
    localparam logic [1:0] KF_DATA = 2'b00;

endpackage

`default_nettype wire

// File: rtl/memfifo_serializer_crc.sv
// crc16_ccitt_16b: combinational CRC-16-CCITT step over one 16-bit word, MSB first.
`default_nettype none

module crc16_ccitt_16b
    import memfifo_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    always_comb begin
        logic [15:0] c;
        c = crc_i;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data_i[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_o = c;
    end

endmodule

`default_nettype wire

// File: rtl/memfifo_serializer.sv
// memfifo_serializer: reads MEMFIFO blocks and frames them as 16-bit SERDES words
// (SOF, length, payload, EOF). Define MEMFIFO_CRC_EN to append a CRC-16 word before EOF.
`default_nettype none

module memfifo_serializer
    import memfifo_pkg::*;
#(
    parameter int          WORDS_PER_PCKT = 2,
    parameter logic [15:0] IDLE_WORD      = K_IDLE
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEMFIFO_DATA_READY,
    input  logic [15:0] MEMFIFO_DATA_PCKTS,
    input  logic [63:0] MEMFIFO_DATA,
    output logic        MEMFIFO_RE,
    output logic [15:0] TX_DATA,
    output logic [1:0]  TX_KCHAR,
    output logic        BUSY,
    output logic        BLOCK_DONE,
    output logic [15:0] PCKT_CNT
);

    state_e      state_q;
    logic        armed_q;
    logic [15:0] npk_q;
    logic [16:0] rem_q;
    logic [63:0] shreg_q;
    logic [1:0]  slice_q;
    logic [15:0] wcnt_q;
    logic [15:0] pckt_cnt_q;
    logic [15:0] tx_q;
    logic [1:0]  kchar_q;
    logic        re_q;
    logic        busy_q;
    logic        done_q;

    logic [16:0] words_d;
    logic [15:0] slice_next_d;

    // 17 bits so that 0xFFFF packets * 2 words cannot wrap
    assign words_d = 17'(MEMFIFO_DATA_PCKTS) * 17'(WORDS_PER_PCKT);

    always_comb begin
        slice_next_d = shreg_q[15:0];
        case (slice_q)
            2'd0:    slice_next_d = shreg_q[47:32];
            2'd1:    slice_next_d = shreg_q[31:16];
            default: slice_next_d = shreg_q[15:0];
        endcase
    end

`ifdef MEMFIFO_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_nxt_d;

    crc16_ccitt_16b u_crc (
        .crc_i  (crc_q),
        .data_i (tx_q),
        .crc_o  (crc_nxt_d)
    );
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            npk_q      <= '0;
            rem_q      <= '0;
            shreg_q    <= '0;
            slice_q    <= '0;
            wcnt_q     <= '0;
            pckt_cnt_q <= '0;
            tx_q       <= IDLE_WORD;
            kchar_q    <= KF_IDLE;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MEMFIFO_CRC_EN
            crc_q      <= CRC_INIT;
`endif
        end else begin
            if (!MEMFIFO_DATA_READY) begin
                armed_q <= 1'b1;
            end
            re_q   <= 1'b0;
            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    tx_q    <= IDLE_WORD;
                    kchar_q <= KF_IDLE;
                    busy_q  <= 1'b0;
                    if (MEMFIFO_DATA_READY && armed_q) begin
                        npk_q      <= MEMFIFO_DATA_PCKTS;
                        rem_q      <= words_d;
                        pckt_cnt_q <= '0;
                        wcnt_q     <= '0;
                        armed_q    <= 1'b0;
                        state_q    <= ST_SOF;
                        tx_q       <= K_SOF;
                        kchar_q    <= KF_CTRL;
                        busy_q     <= 1'b1;
                        re_q       <= (words_d != 17'd0);
`ifdef MEMFIFO_CRC_EN
                        crc_q      <= CRC_INIT;
`endif
                    end
                end

                ST_SOF: begin
                    state_q <= ST_LEN;
                    tx_q    <= npk_q;
                    kchar_q <= KF_DATA;
                end

                ST_LEN: begin
                    if (rem_q != 17'd0) begin
                        shreg_q <= MEMFIFO_DATA;
                        tx_q    <= MEMFIFO_DATA[63:48];
                        slice_q <= 2'd0;
                        state_q <= ST_SHIFT;
                    end else begin
`ifdef MEMFIFO_CRC_EN
                        state_q <= ST_CRC;
                        tx_q    <= crc_q;
`else
                        state_q <= ST_EOF;
                        tx_q    <= K_EOF;
                        kchar_q <= KF_CTRL;
`endif
                    end
                end

                ST_SHIFT: begin
`ifdef MEMFIFO_CRC_EN
                    crc_q <= crc_nxt_d;
`endif
                    if (slice_q != 2'd3) begin
                        tx_q    <= slice_next_d;
                        slice_q <= slice_q + 2'd1;
                        // Request the next word two cycles early so it lands at slice 3
                        if (slice_q == 2'd1 && rem_q > 17'd1) begin
                            re_q <= 1'b1;
                        end
                    end else begin
                        rem_q <= rem_q - 17'd1;
                        if (wcnt_q == 16'(WORDS_PER_PCKT - 1)) begin
                            wcnt_q     <= '0;
                            pckt_cnt_q <= pckt_cnt_q + 16'd1;
                        end else begin
                            wcnt_q <= wcnt_q + 16'd1;
                        end
                        if (rem_q == 17'd1) begin
`ifdef MEMFIFO_CRC_EN
                            state_q <= ST_CRC;
                            tx_q    <= crc_nxt_d;
`else
                            state_q <= ST_EOF;
                            tx_q    <= K_EOF;
                            kchar_q <= KF_CTRL;
`endif
                        end else begin
                            shreg_q <= MEMFIFO_DATA;
                            tx_q    <= MEMFIFO_DATA[63:48];
                            slice_q <= 2'd0;
                        end
                    end
                end

`ifdef MEMFIFO_CRC_EN
                ST_CRC: begin
                    state_q <= ST_EOF;
                    tx_q    <= K_EOF;
                    kchar_q <= KF_CTRL;
                end
`endif

                ST_EOF: begin
                    state_q <= ST_DONE;
                    tx_q    <= IDLE_WORD;
                    kchar_q <= KF_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= IDLE_WORD;
                    kchar_q <= KF_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign MEMFIFO_RE = re_q;
    assign TX_DATA    = tx_q;
    assign TX_KCHAR   = kchar_q;
    assign BUSY       = busy_q;
    assign BLOCK_DONE = done_q;
    assign PCKT_CNT   = pckt_cnt_q;

endmodule

`default_nettype wire

// File: doc/memfifo_serializer.md
Name: memfifo_serializer

Overview:
- Consumer end of the MEMFIFO block interface: accepts a block announced by MEMFIFO_DATA_READY/MEMFIFO_DATA_PCKTS and reads its 64-bit words with a read strobe.
- Serializes each word into 16-bit TOP_SERDES transmit words, framed with SOF, length and EOF K-words.
- Sits between the DDR/simulated-data selection and the TOP_SERDES TX lane; drives idle commas when no block is active.

Parameters:
- WORDS_PER_PCKT, 2, 64-bit words per packet (16-byte packet).
- IDLE_WORD, 16'h3CBC, idle comma (K28.5 in low byte), TX_KCHAR=2'b01.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MEMFIFO_DATA_READY  in  1  a complete block is available in the FIFO.
- MEMFIFO_DATA_PCKTS  in  16  packet count of the block; valid while DATA_READY is high.
- MEMFIFO_DATA  in  64  FIFO read data; valid one cycle after MEMFIFO_RE.
- MEMFIFO_RE  out  1  FIFO read strobe, one word per pulse.
- TX_DATA  out  16  word to TOP_SERDES.
- TX_KCHAR  out  2  per-byte K flag for TX_DATA.
- BUSY  out  1  high from SOF through EOF.
- BLOCK_DONE  out  1  one-cycle pulse in the cycle after EOF.
- PCKT_CNT  out  16  packets fully transmitted in the current or last block.

Behaviour:
- Reset values:
  - MEMFIFO_RE=0, BUSY=0, BLOCK_DONE=0, PCKT_CNT=0.
  - TX_DATA=IDLE_WORD, TX_KCHAR=2'b01.
  - State=IDLE, armed=1.
- Reset mid-block: immediate return to IDLE. Unread FIFO words are not drained.
- States:
  - IDLE:
    - Output the idle word.
    - If DATA_READY & armed: latch PCKTS into npk, set words = npk*WORDS_PER_PCKT (17-bit), clear PCKT_CNT, clear armed, go to SOF.
  - SOF (1 cycle):
    - TX_DATA=16'h1C1C, TX_KCHAR=2'b11 (K28.0).
    - MEMFIFO_RE=1 if words!=0.
    - Go to LEN.
  - LEN (1 cycle):
    - TX_DATA=npk, TX_KCHAR=2'b00.
    - If words!=0: capture MEMFIFO_DATA into shift register at cycle end, go to SHIFT with slice=0. Otherwise go to EOF.
  - SHIFT:
    - Slices 0..3 output DATA[63:48], [47:32], [31:16], [15:0]; TX_KCHAR=2'b00.
    - At slice 2, if more words remain: MEMFIFO_RE=1.
    - At slice 3: capture the next word and decrement the remaining-word count.
    - Every WORDS_PER_PCKT completed words: PCKT_CNT increments.
    - Last word's slice 3: go to EOF (or CRC when the optional feature is enabled).
  - EOF (1 cycle): TX_DATA=16'h9C9C, TX_KCHAR=2'b11 (K28.4). Go to DONE.
  - DONE (1 cycle): BLOCK_DONE=1, output the idle word. Go to IDLE.
- Throughput:
  - No gaps within a block: one 16-bit word per cycle from SOF to EOF.
  - Block length is 3 + 4*words cycles (+1 with CRC), then DONE.
- Re-arm: armed is set whenever DATA_READY is low. A level held high across DONE does not restart a block.
- DATA_READY or PCKTS changes during a block are ignored; npk stays latched.
- PCKTS=0: SOF, LEN(0x0000), EOF, DONE. MEMFIFO_RE never asserts.
- PCKTS=16'hFFFF: words=131070. The 17-bit counter must not wrap.
- BUSY=1 in SOF, LEN, SHIFT, (CRC), EOF.

Optional Feature:
- Macro: MEMFIFO_CRC_EN.
- With the macro defined:
  - A CRC state follows the last SHIFT slice and transmits one data word (TX_KCHAR=2'b00) before EOF.
  - The CRC is CRC-16-CCITT: polynomial 0x1021, init 16'hFFFF, no reflection, no final XOR.
  - It covers all payload TX words. It excludes SOF, LEN and EOF.
  - For PCKTS=0 the CRC word is 16'hFFFF.
- Without the macro: no CRC state and no CRC logic.

Decomposition:
- Package memfifo_pkg:
  - State enum.
  - Constants K_IDLE=16'h3CBC, K_SOF=16'h1C1C, K_EOF=16'h9C9C, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
- Sub-module crc16_ccitt_16b:
  - Combinational next-CRC from 16-bit data plus current CRC.
  - Instantiated only under MEMFIFO_CRC_EN.

Test Plan:
- Reset, then DATA_READY=0 -> TX_DATA=16'h3CBC, TX_KCHAR=01 every cycle. RE, BUSY and BLOCK_DONE stay 0.
- PCKTS=1, FIFO words 64'h0011223344556677, 64'h8899AABBCCDDEEFF ->
  - Output sequence: 1C1C(11), 0001(00), 0011, 2233, 4455, 6677, 8899, AABB, CCDD, EEFF, 9C9C(11).
  - Then BLOCK_DONE pulse, PCKT_CNT=1.
  - Exactly 2 RE pulses: one in SOF, one at slice 2 of word 0.
- PCKTS=0 -> 1C1C, 0000, 9C9C, BLOCK_DONE. Zero RE pulses.
- DATA_READY held high across DONE -> no second SOF until DATA_READY goes low ≥1 cycle and returns high.
- RESET asserted at SHIFT slice 1 of word 3 (PCKTS=4) -> outputs return to their reset values asynchronously. The next block starts cleanly with SOF.
- With MEMFIFO_CRC_EN, PCKTS=1 as in the second scenario -> one extra word between EEFF and 9C9C equal to the reference-model CRC-16-CCITT of the 8 payload words.
